// File: rtl/btn_toggle_pkg.sv
// btn_toggle_pkg: shared FSM state encoding and counter widths for btn_toggle_req
package btn_toggle_pkg;
  localparam int CNT_W = 8;
  localparam int REP_W = 16;
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q;
  // first stage may go metastable; only the second stage is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      q    <= 1'b0;
    end else begin
      s1_q <= d;
      q    <= s1_q;
    end
  end
endmodule

// File: rtl/btn_toggle_req.sv
// btn_toggle_req: debounced button to one-cycle T flip-flop toggle request; BTN_TOGGLE_REQ_REPEAT_EN adds auto-repeat while held
module btn_toggle_req
  import btn_toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t_out,
  output logic level_out,
  output logic busy
);
  localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_param
    $error("btn_toggle_req: parameter out of range");
  end

  logic sync_q;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic t_q, t_d, level_q, level_d, rep_hit;

  sync_2ff u_sync (.clk(clk), .rst(rst), .d(btn_in), .q(sync_q));

  // debounce FSM: a level change is accepted after DEBOUNCE_CYCLES further stable samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    case (state_q)
      IDLE:        if (sync_q) begin
                     state_d = DEB_PRESS;
                     cnt_d   = CNT_W'(1);
                   end
      DEB_PRESS:   if (!sync_q) state_d = IDLE;
                   else if (cnt_q == DEB) begin
                     state_d = PRESSED;
                     t_d     = 1'b1;
                   end else cnt_d = cnt_q + 1'b1;
      PRESSED:     if (!sync_q) begin
                     state_d = DEB_RELEASE;
                     cnt_d   = CNT_W'(1);
                   end
      DEB_RELEASE: if (sync_q) state_d = PRESSED;
                   else if (cnt_q == DEB) state_d = IDLE;
                   else cnt_d = cnt_q + 1'b1;
      default:     state_d = IDLE;
    endcase
    level_d = (state_d == PRESSED) || (state_d == DEB_RELEASE);
  end

`ifdef BTN_TOGGLE_REQ_REPEAT_EN
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q, rep_d;
  // repeat counter only runs while the button stays held in PRESSED
  always_comb begin
    rep_hit = (state_q == PRESSED) && sync_q && (rep_q == REP_LAST);
    rep_d   = ((state_q == PRESSED) && sync_q && !rep_hit) ? rep_q + 1'b1 : '0;
  end
  // repeat counter register
  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else rep_q <= rep_d;
  end
`else
  assign rep_hit = 1'b0;
`endif

  // state, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d | rep_hit;
      level_q <= level_d;
    end
  end

  assign t_out     = t_q;
  assign level_out = level_q;
  assign busy      = (state_q == DEB_PRESS) || (state_q == DEB_RELEASE);
endmodule
